sram_arbiter: RTL and testbench
===============================

# sram_arbiter

Sequences the board's external 256K×32 asynchronous SRAM (two 16-bit chips sharing address and /WE, /OE) and shares it between two requesters: port 0 (68000 bus interface) and port 1 (DMA/video fetch). It sits inside `system` between the requesters and the `ram_*` pins, generating all chip-enable, byte-lane and strobe timing from the 25 MHz system clock. It also replaces ad-hoc strobe generation in the CPU bus logic.

## Interface
Parameters:
- READ_WAIT, 1: cycles /OE is held before read data is sampled (≥1).
- WRITE_WAIT, 1: cycles /WE is held low (≥1).

Ports:
- clk  in  1  system clock (25 MHz); one clock; reset is synchronous and active-low
- reset_n  in  1  synchronous active-low reset
- pN_req  in  1  port N (N=0,1) request; held until pN_ack
- pN_we  in  1  1 = write, 0 = read
- pN_addr  in  18  32-bit word address
- pN_be  in  4  byte enables; bit i ↔ data[8i+7:8i]
- pN_wdata  in  32  write data
- pN_rdata  out  32  read data, valid in the pN_ack cycle
- pN_ack  out  1  one-cycle completion pulse
- ram_addr  out  18  SRAM address
- ram_data_read  in  32  SRAM data bus, input side
- ram_data_write  out  32  SRAM data bus, output side
- ram_data_is_output  out  1  tristate enable for ram_data_write
- ram_ce_n, ram_ub_n, ram_lb_n, ram_we_n, ram_oe_n  out  2 each  per-chip strobes; chip 0 = data[15:0], chip 1 = data[31:16]

## Operation
- States: IDLE → READ (READ_WAIT cycles) → ACK → IDLE. Writes: IDLE → WSETUP (1 cycle) → WPULSE (WRITE_WAIT cycles) → WHOLD/ACK (1 cycle) → IDLE.
- IDLE samples requests. If exactly one request is pending, that port is granted. On a conflict, the grant is chosen by the arbitration policy described under Configuration. The granted port's we/addr/be/wdata are latched at the grant edge.
- Byte lanes:
  - ram_lb_n[0] = ~be[0], ram_ub_n[0] = ~be[1], ram_lb_n[1] = ~be[2], ram_ub_n[1] = ~be[3].
  - ram_ce_n[k] is low only when chip k has at least one enabled lane and the state is not IDLE.
  - be = 0 completes with ack, but no chip is selected.
- Reads:
  - ce/oe are asserted in every READ cycle.
  - ram_data_read is registered into pN_rdata at the last READ edge.
  - oe is released in ACK.
  - Disabled lanes of pN_rdata read as 0.
- Writes:
  - addr, data, ce and lanes are driven from WSETUP until the end of WHOLD.
  - ram_data_is_output = 1 only in WSETUP/WPULSE/WHOLD.
  - we_n is low only in WPULSE.
  - oe_n stays high throughout.
- pN_ack pulses for exactly one cycle, only to the granted port. The requester must drop req on the edge where it sees ack. A req still high in the following IDLE cycle is treated as a new request.
- All ram_* outputs are registered; there are no combinational paths from pN_* to pins.

## Timing
- Reset values: ram_ce_n/ub_n/lb_n/we_n/oe_n = 2'b11, ram_data_is_output = 0, ram_addr = 0, ram_data_write = 0, pN_ack = 0, pN_rdata = 0, state IDLE, RR pointer = port 0.
- Read: ack goes high READ_WAIT+1 cycles after the IDLE cycle that samples req. With the defaults, req at c0 gives ack at c2, and the next grant can occur at c3.
- Write: ack goes high WRITE_WAIT+2 cycles after the sampling IDLE cycle. With the defaults, ack is at c3.
- Back-to-back accesses always pass through one IDLE cycle, which guarantees bus turnaround between a write's drive and a read's /OE.
- Reset asserted mid-access forces all strobes inactive at the next edge, and no ack is issued. A write interrupted in WPULSE leaves the target word undefined.
- A request deasserted before ack is a protocol violation. The access still completes and the ack is still issued.

## Configuration
- SRAM_ARB_ROUND_ROBIN_EN defined: on a conflict, the port that was not granted last wins. The pointer updates on every grant.
- Undefined: fixed priority, with port 0 always winning. Port 1 is served only when p0_req is low in IDLE.

## Structure
- Package sram_arbiter_pkg holds the state enum (IDLE, READ, ACK, WSETUP, WPULSE, WHOLD), port count constant 2, and address/data width constants (18/32).
- One sub-module: sram_arb_grant. It contains the combinational pick from two reqs plus the last-grant register, and contains the macro-dependent logic.
- Wait-cycle counter and FSM live in sram_arbiter.

## Test plan
- Port 0 reads address 0x00010 holding 0xDEADBEEF with be=4'hF → ce_n=00 and oe_n=00 for 1 cycle, ack at c2, p0_rdata=0xDEADBEEF, no we_n activity.
- Port 1 writes 0x12345678 to 0x3FFFF with be=4'b0010 → only ce_n[0]=0 and ub_n[0]=0, we_n low exactly 1 cycle, data driven for 3 cycles, ack at c3. A read-back returns 0x00005600.
- Both reqs high continuously for 4 accesses → grants go 0,1,0,1 with the macro and 0,0,0,0 without it. Exactly one ack per cycle maximum.
- Write immediately followed by a read → one IDLE cycle in which ram_data_is_output=0 and oe_n=11 before the read's oe.
- reset_n dropped during WPULSE → next edge has we_n=11, ce_n=11, data_is_output=0 and no ack. After release the first request is served normally.
- READ_WAIT=3, WRITE_WAIT=2 → read ack at c4, write ack at c4, with /WE low exactly 2 cycles.

Source files
------------

// File: rtl/sram_arbiter_pkg.sv
// Shared types and helpers for the two-port external SRAM arbiter.
package sram_arbiter_pkg;

   localparam int NPORTS = 2;
   localparam int ADDR_W = 18;
   localparam int DATA_W = 32;

   typedef enum logic [2:0] {
      IDLE,
      READ,
      ACK,
      WSETUP,
      WPULSE,
      WHOLD
   } state_t;

   typedef struct packed {
      state_t state;
      logic   last_grant;
   } dbg_t;

   function automatic logic [DATA_W-1:0] lane_mask(input logic [3:0] be);
      return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
   endfunction

   // Chip 0 carries lanes 0/1, chip 1 carries lanes 2/3.
   function automatic logic [1:0] chip_sel_n(input logic [3:0] be);
      return {~|be[3:2], ~|be[1:0]};
   endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// One requester port of the SRAM arbiter.
// Handshake: req (with we/addr/be/wdata) is held stable until ack; ack is a
// one-cycle pulse, rdata is valid in the ack cycle, and req drops on that edge.
interface sram_arbiter_if;
   import sram_arbiter_pkg::*;

   logic              req;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [3:0]        be;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata;
   logic              ack;

   modport master (output req, we, addr, be, wdata, input rdata, ack);
   modport slave  (input req, we, addr, be, wdata, output rdata, ack);
endinterface

// File: rtl/sram_arb_grant.sv
// Grant selection between the two requesters plus the last-grant register.
// SRAM_ARB_ROUND_ROBIN_EN selects round-robin; otherwise port 0 has fixed priority.
module sram_arb_grant
   import sram_arbiter_pkg::*;
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic [NPORTS-1:0] req,
   input  logic              take,
   output logic              valid,
   output logic              sel,
   output logic              last_grant
);

   logic last_q;

   always_comb begin
      valid = |req;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      sel = (req[0] & req[1]) ? ~last_q : ~req[0];
`else
      sel = ~req[0];
`endif
   end

   // Reset value 1 makes port 0 the winner of the first conflict.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         last_q <= 1'b1;
      end else if (take && valid) begin
         last_q <= sel;
      end
   end

   assign last_grant = last_q;

endmodule

// File: rtl/sram_arbiter.sv
// Two-port sequencer for the 256Kx32 asynchronous SRAM; all ram_* pins registered.
// Arbitration policy set by SRAM_ARB_ROUND_ROBIN_EN (see sram_arb_grant).
module sram_arbiter
   import sram_arbiter_pkg::*;
#(
   parameter int unsigned READ_WAIT  = 1,
   parameter int unsigned WRITE_WAIT = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   sram_arbiter_if.slave     p0,
   sram_arbiter_if.slave     p1,
   output logic [ADDR_W-1:0] ram_addr,
   input  logic [DATA_W-1:0] ram_data_read,
   output logic [DATA_W-1:0] ram_data_write,
   output logic              ram_data_is_output,
   output logic [1:0]        ram_ce_n,
   output logic [1:0]        ram_ub_n,
   output logic [1:0]        ram_lb_n,
   output logic [1:0]        ram_we_n,
   output logic [1:0]        ram_oe_n,
   output dbg_t              dbg
);

   localparam logic [7:0] RW_LAST = 8'(READ_WAIT - 1);
   localparam logic [7:0] WW_LAST = 8'(WRITE_WAIT - 1);

   state_t            state;
   logic [7:0]        cnt;
   logic              cur_port;
   logic [3:0]        cur_be;
   logic [NPORTS-1:0] ack_q;
   logic [DATA_W-1:0] rdata_q [NPORTS];

   logic              gnt_valid, gnt_sel, last_grant;
   logic              req_we;
   logic [ADDR_W-1:0] req_addr;
   logic [3:0]        req_be;
   logic [DATA_W-1:0] req_wdata;

   sram_arb_grant u_grant (
      .clk        (clk),
      .reset_n    (reset_n),
      .req        ({p1.req, p0.req}),
      .take       (state == IDLE),
      .valid      (gnt_valid),
      .sel        (gnt_sel),
      .last_grant (last_grant)
   );

   always_comb begin
      req_we    = p0.we;
      req_addr  = p0.addr;
      req_be    = p0.be;
      req_wdata = p0.wdata;
      if (gnt_sel) begin
         req_we    = p1.we;
         req_addr  = p1.addr;
         req_be    = p1.be;
         req_wdata = p1.wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state              <= IDLE;
         cnt                <= '0;
         cur_port           <= 1'b0;
         cur_be             <= '0;
         ack_q              <= '0;
         rdata_q[0]         <= '0;
         rdata_q[1]         <= '0;
         ram_addr           <= '0;
         ram_data_write     <= '0;
         ram_data_is_output <= 1'b0;
         ram_ce_n           <= 2'b11;
         ram_ub_n           <= 2'b11;
         ram_lb_n           <= 2'b11;
         ram_we_n           <= 2'b11;
         ram_oe_n           <= 2'b11;
      end else begin
         ack_q <= '0;
         unique case (state)
            IDLE: begin
               if (gnt_valid) begin
                  cur_port <= gnt_sel;
                  cur_be   <= req_be;
                  cnt      <= '0;
                  ram_addr <= req_addr;
                  ram_ce_n <= chip_sel_n(req_be);
                  ram_ub_n <= {~req_be[3], ~req_be[1]};
                  ram_lb_n <= {~req_be[2], ~req_be[0]};
                  if (req_we) begin
                     ram_data_write     <= req_wdata;
                     ram_data_is_output <= 1'b1;
                     state              <= WSETUP;
                  end else begin
                     ram_oe_n <= 2'b00;
                     state    <= READ;
                  end
               end
            end
            READ: begin
               if (cnt == RW_LAST) begin
                  rdata_q[cur_port] <= ram_data_read & lane_mask(cur_be);
                  ack_q[cur_port]   <= 1'b1;
                  ram_oe_n          <= 2'b11;
                  state             <= ACK;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            ACK: begin
               ram_ce_n <= 2'b11;
               ram_ub_n <= 2'b11;
               ram_lb_n <= 2'b11;
               state    <= IDLE;
            end
            WSETUP: begin
               ram_we_n <= 2'b00;
               cnt      <= '0;
               state    <= WPULSE;
            end
            WPULSE: begin
               if (cnt == WW_LAST) begin
                  ram_we_n        <= 2'b11;
                  ack_q[cur_port] <= 1'b1;
                  state           <= WHOLD;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            WHOLD: begin
               // Data stays driven through the hold cycle, released in the IDLE gap.
               ram_ce_n           <= 2'b11;
               ram_ub_n           <= 2'b11;
               ram_lb_n           <= 2'b11;
               ram_data_is_output <= 1'b0;
               ram_data_write     <= '0;
               state              <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign p0.ack   = ack_q[0];
   assign p1.ack   = ack_q[1];
   assign p0.rdata = rdata_q[0];
   assign p1.rdata = rdata_q[1];

   assign dbg.state      = state;
   assign dbg.last_grant = last_grant;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed and randomized checks of sram_arbiter against a word-level SRAM model.
module tb_sram_arbiter;
   import sram_arbiter_pkg::*;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #20 clk = ~clk;

   // ---------------- DUTs ----------------
   sram_arbiter_if p0_if ();
   sram_arbiter_if p1_if ();
   sram_arbiter_if sp0_if ();
   sram_arbiter_if sp1_if ();

   logic [17:0] ram_addr, s_addr;
   logic [31:0] ram_data_read, ram_data_write, s_data_read, s_data_write;
   logic        ram_dio, s_dio;
   logic [1:0]  ram_ce_n, ram_ub_n, ram_lb_n, ram_we_n, ram_oe_n;
   logic [1:0]  s_ce_n, s_ub_n, s_lb_n, s_we_n, s_oe_n;
   dbg_t        dbg, s_dbg;

   sram_arbiter #(.READ_WAIT(1), .WRITE_WAIT(1)) dut (
      .clk(clk), .reset_n(reset_n), .p0(p0_if), .p1(p1_if),
      .ram_addr(ram_addr), .ram_data_read(ram_data_read), .ram_data_write(ram_data_write),
      .ram_data_is_output(ram_dio), .ram_ce_n(ram_ce_n), .ram_ub_n(ram_ub_n),
      .ram_lb_n(ram_lb_n), .ram_we_n(ram_we_n), .ram_oe_n(ram_oe_n), .dbg(dbg)
   );

   sram_arbiter #(.READ_WAIT(3), .WRITE_WAIT(2)) dut_slow (
      .clk(clk), .reset_n(reset_n), .p0(sp0_if), .p1(sp1_if),
      .ram_addr(s_addr), .ram_data_read(s_data_read), .ram_data_write(s_data_write),
      .ram_data_is_output(s_dio), .ram_ce_n(s_ce_n), .ram_ub_n(s_ub_n),
      .ram_lb_n(s_lb_n), .ram_we_n(s_we_n), .ram_oe_n(s_oe_n), .dbg(s_dbg)
   );

   // ---------------- pin-level SRAM for the default DUT ----------------
   logic [31:0] pin_mem [0:(1<<18)-1];
   logic        bd_en = 1'b0;
   logic [17:0] bd_addr = '0;
   logic [31:0] bd_data = '0;
   wire  [31:0] cur_word = pin_mem[ram_addr];

   assign ram_data_read[15:0]  = (!ram_ce_n[0] && !ram_oe_n[0]) ? cur_word[15:0]  : 16'h5A5A;
   assign ram_data_read[31:16] = (!ram_ce_n[1] && !ram_oe_n[1]) ? cur_word[31:16] : 16'h5A5A;

   always @(posedge clk) begin
      if (bd_en) pin_mem[bd_addr] <= bd_data;
      for (int k = 0; k < 2; k++) begin
         if (!ram_ce_n[k] && !ram_we_n[k]) begin
            if (!ram_lb_n[k]) pin_mem[ram_addr][16*k +: 8]   <= ram_data_write[16*k +: 8];
            if (!ram_ub_n[k]) pin_mem[ram_addr][16*k+8 +: 8] <= ram_data_write[16*k+8 +: 8];
         end
      end
   end

   // Slow DUT sees a fixed word on whichever chip it selects for reading.
   logic [31:0] s_rd_val = '0;
   assign s_data_read[15:0]  = (!s_ce_n[0] && !s_oe_n[0]) ? s_rd_val[15:0]  : 16'h5A5A;
   assign s_data_read[31:16] = (!s_ce_n[1] && !s_oe_n[1]) ? s_rd_val[31:16] : 16'h5A5A;

   // Pin view of whichever DUT is currently targeted.
   bit tgt = 1'b0;
   wire [1:0]  v_ce_n = tgt ? s_ce_n : ram_ce_n;
   wire [1:0]  v_ub_n = tgt ? s_ub_n : ram_ub_n;
   wire [1:0]  v_lb_n = tgt ? s_lb_n : ram_lb_n;
   wire [1:0]  v_we_n = tgt ? s_we_n : ram_we_n;
   wire [1:0]  v_oe_n = tgt ? s_oe_n : ram_oe_n;
   wire        v_dio  = tgt ? s_dio  : ram_dio;
   wire [17:0] v_addr = tgt ? s_addr : ram_addr;
   wire [31:0] v_dw   = tgt ? s_data_write : ram_data_write;

   // ---------------- scoreboard / reference model ----------------
   int          total = 0;
   int          bad = 0;
   int          last_gnt = 1;
   logic [31:0] ref_mem [logic [17:0]];
   logic [31:0] exp_q [$];
   logic [17:0] pool [8];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mask_of(input logic [3:0] be);
      logic [31:0] m = '0;
      for (int i = 0; i < 4; i++) if (be[i]) m[8*i +: 8] = 8'hFF;
      return m;
   endfunction

   function automatic logic [31:0] ref_read(input logic [17:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
   endfunction

   task automatic ref_write(input logic [17:0] a, input logic [3:0] be, input logic [31:0] wd);
      logic [31:0] m = mask_of(be);
      ref_mem[a] = (ref_read(a) & ~m) | (wd & m);
   endtask

   // ---------------- driver tasks ----------------
   task automatic set_port(input int p, input logic r, input logic we, input logic [17:0] a,
                           input logic [3:0] be, input logic [31:0] wd);
      if (tgt) begin
         sp0_if.req = r; sp0_if.we = we; sp0_if.addr = a; sp0_if.be = be; sp0_if.wdata = wd;
      end else if (p == 0) begin
         p0_if.req = r; p0_if.we = we; p0_if.addr = a; p0_if.be = be; p0_if.wdata = wd;
      end else begin
         p1_if.req = r; p1_if.we = we; p1_if.addr = a; p1_if.be = be; p1_if.wdata = wd;
      end
   endtask

   task automatic set_req(input int p, input logic r);
      if (tgt) sp0_if.req = r;
      else if (p == 0) p0_if.req = r;
      else p1_if.req = r;
   endtask

   task automatic backdoor(input logic [17:0] a, input logic [31:0] d);
      @(negedge clk);
      bd_addr = a; bd_data = d; bd_en = 1'b1;
      @(negedge clk);
      bd_en = 1'b0;
      ref_mem[a] = d;
   endtask

   // One access from an IDLE cycle; checks latency, strobes, and data.
   task automatic access(input int p, input logic we, input logic [17:0] a,
                         input logic [3:0] be, input logic [31:0] wd);
      int rw = tgt ? 3 : 1;
      int ww = tgt ? 2 : 1;
      int lat = 0, oe_c = 0, we_c = 0, drv_c = 0, oth = 0;
      bit seen = 1'b0;
      logic mack, oack;
      logic [31:0] mrd, c_dw = '0, c_rd = '0;
      logic [1:0] c_ce = '0, c_ub = '0, c_lb = '0, exp_ce;
      logic [17:0] c_addr = '0;
      for (int k = 0; k < 2; k++) exp_ce[k] = (be[2*k +: 2] == 2'b00);

      @(negedge clk);
      chk("idle_gap", {25'b0, v_dio, v_oe_n, v_we_n, v_ce_n}, {25'b0, 1'b0, 6'b111111});
      if (!we) exp_q.push_back((tgt ? s_rd_val : ref_read(a)) & mask_of(be));
      else if (!tgt) ref_write(a, be, wd);
      set_port(p, 1'b1, we, a, be, wd);

      while (!seen && lat < 40) begin
         @(negedge clk);
         lat++;
         if (tgt) begin mack = sp0_if.ack; oack = sp1_if.ack; mrd = sp0_if.rdata; end
         else if (p == 0) begin mack = p0_if.ack; oack = p1_if.ack; mrd = p0_if.rdata; end
         else begin mack = p1_if.ack; oack = p0_if.ack; mrd = p1_if.rdata; end
         if (v_oe_n != 2'b11) oe_c++;
         if (v_we_n != 2'b11) we_c++;
         if (v_dio) drv_c++;
         if (oack) oth++;
         if (lat == 1) begin
            c_ce = v_ce_n; c_ub = v_ub_n; c_lb = v_lb_n; c_addr = v_addr; c_dw = v_dw;
         end
         if (mack) begin
            seen = 1'b1;
            c_rd = mrd;
            set_req(p, 1'b0);
         end
      end
      if (!seen) set_req(p, 1'b0);

      chk("latency", lat, we ? ww + 2 : rw + 1);
      chk("ce_n", {30'b0, c_ce}, {30'b0, exp_ce});
      chk("ub_n", {30'b0, c_ub}, {30'b0, ~be[3], ~be[1]});
      chk("lb_n", {30'b0, c_lb}, {30'b0, ~be[2], ~be[0]});
      chk("ram_addr", {14'b0, c_addr}, {14'b0, a});
      chk("oe_cycles", oe_c, we ? 0 : rw);
      chk("we_cycles", we_c, we ? ww : 0);
      chk("drive_cycles", drv_c, we ? ww + 2 : 0);
      chk("other_ack", oth, 0);
      if (we) chk("wdata_pins", c_dw, wd);
      else chk("rdata", c_rd, exp_q.pop_front());
      if (!tgt) last_gnt = p;
   endtask

   // ---------------- continuous protocol checks ----------------
   always @(negedge clk) begin
      if (reset_n) begin
         chk("one_ack", {31'b0, p0_if.ack & p1_if.ack}, 32'h0);
         chk("turnaround", {31'b0, (ram_oe_n != 2'b11) && ram_dio}, 32'h0);
         chk("we_needs_drive", {31'b0, (ram_we_n != 2'b11) && !ram_dio}, 32'h0);
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      set_port(0, 1'b0, 1'b0, '0, '0, '0);
      set_port(1, 1'b0, 1'b0, '0, '0, '0);
      sp0_if.req = 1'b0; sp0_if.we = 1'b0; sp0_if.addr = '0; sp0_if.be = '0; sp0_if.wdata = '0;
      sp1_if.req = 1'b0; sp1_if.we = 1'b0; sp1_if.addr = '0; sp1_if.be = '0; sp1_if.wdata = '0;
      reset_n = 1'b0;
      repeat (3) @(negedge clk);

      chk("rst_strobes", {22'b0, ram_ce_n, ram_ub_n, ram_lb_n, ram_we_n, ram_oe_n}, 32'h3FF);
      chk("rst_dio", {31'b0, ram_dio}, 32'h0);
      chk("rst_addr", {14'b0, ram_addr}, 32'h0);
      chk("rst_wdata", ram_data_write, 32'h0);
      chk("rst_ack", {30'b0, p1_if.ack, p0_if.ack}, 32'h0);
      chk("rst_rdata0", p0_if.rdata, 32'h0);
      chk("rst_rdata1", p1_if.rdata, 32'h0);
      chk("rst_state", {29'b0, dbg.state}, {29'b0, IDLE});
      reset_n = 1'b1;

      // Directed: read, partial write, write-then-read turnaround.
      backdoor(18'h00010, 32'hDEADBEEF);
      access(0, 1'b0, 18'h00010, 4'hF, 32'h0);
      access(1, 1'b1, 18'h3FFFF, 4'b0010, 32'h12345678);
      access(0, 1'b0, 18'h3FFFF, 4'b0010, 32'h0);
      chk("readback_value", p0_if.rdata, 32'h00005600);

      // Randomized: initialise a pool of words, then mixed traffic.
      pool[0] = 18'h00010;
      pool[1] = 18'h3FFFF;
      for (int i = 2; i < 8; i++) pool[i] = 18'($urandom_range(0, 18'h1FFFF));
      for (int i = 0; i < 8; i++)
         access(int'($urandom_range(0, 1)), 1'b1, pool[i], 4'hF, $urandom);
      for (int i = 0; i < 24; i++)
         access(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                pool[$urandom_range(0, 7)], 4'($urandom_range(0, 15)), $urandom);

      // Conflict: both ports request continuously for four reads.
      begin : conflict
         int n, guard, w, exp_w;
         @(negedge clk);
         set_port(0, 1'b1, 1'b0, pool[2], 4'hF, 32'h0);
         set_port(1, 1'b1, 1'b0, pool[3], 4'hF, 32'h0);
         n = 0; guard = 0;
         while (n < 4 && guard < 60) begin
            @(negedge clk);
            guard++;
            if (!p0_if.req) p0_if.req = 1'b1;
            if (!p1_if.req) p1_if.req = 1'b1;
            if (p0_if.ack || p1_if.ack) begin
               w = p1_if.ack ? 1 : 0;
               exp_w = RR ? 1 - last_gnt : 0;
               chk("grant_order", w, exp_w);
               chk("conflict_rdata", w ? p1_if.rdata : p0_if.rdata, ref_read(w ? pool[3] : pool[2]));
               last_gnt = w;
               n++;
               if (w == 1) p1_if.req = 1'b0; else p0_if.req = 1'b0;
            end
         end
         p0_if.req = 1'b0;
         p1_if.req = 1'b0;
         chk("conflict_count", n, 4);
      end

      // Reset during the write pulse.
      begin : rst_mid
         int g;
         @(negedge clk);
         set_port(1, 1'b1, 1'b1, 18'h2AAAA, 4'hF, $urandom);
         g = 0;
         while (ram_we_n == 2'b11 && g < 20) begin
            @(negedge clk);
            g++;
         end
         chk("reach_wpulse", {30'b0, ram_we_n}, 32'h0);
         reset_n = 1'b0;
         @(negedge clk);
         chk("rst_mid_we", {30'b0, ram_we_n}, 32'h3);
         chk("rst_mid_ce", {30'b0, ram_ce_n}, 32'h3);
         chk("rst_mid_dio", {31'b0, ram_dio}, 32'h0);
         chk("rst_mid_ack", {30'b0, p1_if.ack, p0_if.ack}, 32'h0);
         chk("rst_mid_state", {29'b0, dbg.state}, {29'b0, IDLE});
         set_req(1, 1'b0);
         @(negedge clk);
         reset_n = 1'b1;
         last_gnt = 1;
      end
      access(0, 1'b0, pool[0], 4'hF, 32'h0);

      // Longer wait states on the second instance.
      tgt = 1'b1;
      s_rd_val = $urandom;
      access(0, 1'b0, 18'h00155, 4'hF, 32'h0);
      access(0, 1'b1, 18'h00156, 4'b0011, $urandom);
      access(0, 1'b0, 18'h00157, 4'b1100, 32'h0);
      tgt = 1'b0;

      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
